// File: rtl/scan_mux_if.sv
// rtl/scan_mux_if.sv - scan_mux channel/select/output bundle; SCAN_CHMASK_EN adds CHMASK
interface scan_mux_if #(
  parameter int W    = 2,
  parameter int N    = 4,
  parameter int SELW = 2
);
  logic              EN;
  logic              MODE;
  logic [SELW-1:0]   S;
  logic [N*W-1:0]    D;
  logic [W-1:0]      Y;
  logic [SELW-1:0]   CH;
  logic              VALID;
`ifdef SCAN_CHMASK_EN
  logic [N-1:0]      CHMASK;

  modport master (output EN, MODE, S, D, CHMASK, input Y, CH, VALID);
  modport slave  (input EN, MODE, S, D, CHMASK, output Y, CH, VALID);
`else
  modport master (output EN, MODE, S, D, input Y, CH, VALID);
  modport slave  (input EN, MODE, S, D, output Y, CH, VALID);
`endif
endinterface

// File: rtl/scan_mux.sv
// rtl/scan_mux.sv - N-channel registered mux, manual select or dwell-timed scan; SCAN_CHMASK_EN adds a scan skip mask
module scan_mux #(
  parameter int W     = 2,
  parameter int N     = 4,
  parameter int SELW  = 2,
  parameter int DWELL = 4
) (
  input  logic      CLK,
  input  logic      RST_N,
  scan_mux_if.slave bus
);
  localparam int              CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL - 1);
  localparam logic [1:0]      ST_DIS   = 2'd0;
  localparam logic [1:0]      ST_MAN   = 2'd1;
  localparam logic [1:0]      ST_SCN   = 2'd2;

  logic [W-1:0]    y_q;
  logic [SELW-1:0] ch_q;
  logic            valid_q;
  logic [SELW-1:0] scan_ch;
  logic [CW-1:0]   dwell_cnt;
  logic            mode_q;

  logic [1:0]      st;
  logic            restart;
  logic [SELW-1:0] first_ch;
  logic [SELW-1:0] cur_ch;
  logic [SELW-1:0] step_ch;
  logic [SELW-1:0] nxt_ch;
  logic [CW-1:0]   cur_cnt;
  logic [CW-1:0]   nxt_cnt;
  logic            at_last;
  logic            man_ok;
  logic            scan_ok;
  logic [W-1:0]    man_y;
  logic [W-1:0]    scan_y;

  // Effective state: disable wins over mode
  always_comb begin
    if (bus.EN)        st = ST_DIS;
    else if (bus.MODE) st = ST_SCN;
    else               st = ST_MAN;
  end

  // A 0->1 MODE edge while enabled restarts the scan; this edge already
  // produces the first output of the restarted channel, so it counts as
  // dwell cycle 0 and the channel is shown for a full DWELL cycles.
  assign restart = (st == ST_SCN) && !mode_q;
  assign cur_ch  = restart ? first_ch : scan_ch;
  assign cur_cnt = restart ? '0 : dwell_cnt;
  assign at_last = (cur_cnt == CNT_LAST);
  assign nxt_ch  = at_last ? step_ch : cur_ch;
  assign nxt_cnt = at_last ? '0 : cur_cnt + 1'b1;
  assign man_ok  = int'(bus.S) < N;

`ifdef SCAN_CHMASK_EN
  logic            any_open;
  logic [SELW-1:0] low_ch;
  logic            above_open;
  logic [SELW-1:0] above_ch;
  logic            cur_open;

  // Lowest unmasked channel: restart target and wrap-around target
  always_comb begin
    any_open = 1'b0;
    low_ch   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (!bus.CHMASK[k]) begin
        any_open = 1'b1;
        low_ch   = SELW'(k);
      end
    end
  end

  // First unmasked channel above the current one, and whether the current one is still open
  always_comb begin
    above_open = 1'b0;
    above_ch   = '0;
    cur_open   = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (!bus.CHMASK[k] && (k > int'(cur_ch))) begin
        above_open = 1'b1;
        above_ch   = SELW'(k);
      end
      if (k == int'(cur_ch)) cur_open = !bus.CHMASK[k];
    end
  end

  assign first_ch = any_open ? low_ch : scan_ch;
  assign step_ch  = above_open ? above_ch : (any_open ? low_ch : cur_ch);
  assign scan_ok  = any_open && cur_open;
`else
  localparam logic [SELW-1:0] CH_LAST = SELW'(N - 1);

  assign first_ch = '0;
  assign step_ch  = (cur_ch == CH_LAST) ? '0 : cur_ch + 1'b1;
  assign scan_ok  = 1'b1;
`endif

  // Channel data for the manual and the scan selection
  always_comb begin
    man_y  = '0;
    scan_y = '0;
    for (int k = 0; k < N; k++) begin
      if (int'(bus.S) == k)  man_y  = bus.D[k*W +: W];
      if (int'(cur_ch) == k) scan_y = bus.D[k*W +: W];
    end
  end

  // Output registers, scan position and mode history
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      y_q       <= '0;
      ch_q      <= '0;
      valid_q   <= 1'b0;
      scan_ch   <= '0;
      dwell_cnt <= '0;
      mode_q    <= 1'b0;
    end else begin
      mode_q <= bus.MODE;
      case (st)
        ST_DIS: begin
          y_q     <= '0;
          valid_q <= 1'b0;
        end
        ST_MAN: begin
          ch_q    <= bus.S;
          y_q     <= man_ok ? man_y : '0;
          valid_q <= man_ok;
        end
        default: begin
          ch_q      <= cur_ch;
          scan_ch   <= nxt_ch;
          dwell_cnt <= nxt_cnt;
          y_q       <= scan_ok ? scan_y : '0;
          valid_q   <= scan_ok;
        end
      endcase
    end
  end

  assign bus.Y     = y_q;
  assign bus.CH    = ch_q;
  assign bus.VALID = valid_q;

endmodule

// File: tb/tb_scan_mux.sv
// tb/tb_scan_mux.sv - table and scoreboard bench for scan_mux (N=4 and N=3 builds, mask build under SCAN_CHMASK_EN)
module tb_scan_mux;
  logic clk;
  logic rst_n4;
  logic rst_n3;
  logic rst_nm;

  typedef struct {
    int         dut;
    logic       rst;
    logic       en;
    logic       mode;
    logic [1:0] s;
    logic [7:0] d;
    logic [3:0] mask;
    logic [1:0] y;
    logic [1:0] ch;
    logic       v;
  } vec_t;

  typedef struct {
    logic [1:0] y;
    logic [1:0] ch;
    logic       v;
    int         id;
  } exp_t;

  exp_t sbq[$];
  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   vid   = 0;

  scan_mux_if #(.W(2), .N(4), .SELW(2)) if4 ();
  scan_mux_if #(.W(2), .N(3), .SELW(2)) if3 ();

  scan_mux #(.W(2), .N(4), .SELW(2), .DWELL(4)) u4 (.CLK(clk), .RST_N(rst_n4), .bus(if4));
  scan_mux #(.W(2), .N(3), .SELW(2), .DWELL(2)) u3 (.CLK(clk), .RST_N(rst_n3), .bus(if3));

`ifdef SCAN_CHMASK_EN
  scan_mux_if #(.W(2), .N(4), .SELW(2)) ifm ();
  scan_mux #(.W(2), .N(4), .SELW(2), .DWELL(1)) um (.CLK(clk), .RST_N(rst_nm), .bus(ifm));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(int dut, bit rst, bit en, bit mode, int s, logic [7:0] d,
                              logic [3:0] mask, int y, int ch, bit v);
    vec_t t;
    t.dut = dut; t.rst = rst; t.en = en; t.mode = mode; t.s = 2'(s); t.d = d;
    t.mask = mask; t.y = 2'(y); t.ch = 2'(ch); t.v = v;
    return t;
  endfunction

  function automatic int sel(logic [7:0] d, int c);
    return int'(d[c*2 +: 2]);
  endfunction

  task automatic chk(input int id, input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL vec %0d %s: got %0d, expected %0d", id, nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    int   ay, ach, av;
    case (v.dut)
      0: begin
        rst_n4 = !v.rst; if4.EN = v.en; if4.MODE = v.mode; if4.S = v.s; if4.D = v.d;
      end
      1: begin
        rst_n3 = !v.rst; if3.EN = v.en; if3.MODE = v.mode; if3.S = v.s; if3.D = v.d[5:0];
      end
      default: begin
`ifdef SCAN_CHMASK_EN
        rst_nm = !v.rst; ifm.EN = v.en; ifm.MODE = v.mode; ifm.S = v.s; ifm.D = v.d;
        ifm.CHMASK = v.mask;
`endif
      end
    endcase
    e.y = v.y; e.ch = v.ch; e.v = v.v; e.id = vid;
    sbq.push_back(e);
    vid++;
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    ay = 0; ach = 0; av = 0;
    case (v.dut)
      0: begin ay = int'(if4.Y); ach = int'(if4.CH); av = int'(if4.VALID); end
      1: begin ay = int'(if3.Y); ach = int'(if3.CH); av = int'(if3.VALID); end
      default: begin
`ifdef SCAN_CHMASK_EN
        ay = int'(ifm.Y); ach = int'(ifm.CH); av = int'(ifm.VALID);
`endif
      end
    endcase
    chk(e.id, "Y", ay, int'(e.y));
    chk(e.id, "CH", ach, int'(e.ch));
    chk(e.id, "VALID", av, int'(e.v));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int         c;

    rst_n4 = 1'b0; rst_n3 = 1'b0; rst_nm = 1'b0;
    if4.EN = 1'b1; if4.MODE = 1'b0; if4.S = '0; if4.D = '0;
    if3.EN = 1'b1; if3.MODE = 1'b0; if3.S = '0; if3.D = '0;
`ifdef SCAN_CHMASK_EN
    if4.CHMASK = '0; if3.CHMASK = '0;
    ifm.EN = 1'b1; ifm.MODE = 1'b0; ifm.S = '0; ifm.D = '0; ifm.CHMASK = '0;
`endif

    // N=4, D = 11_10_01_00
    tbl.push_back(mk(0, 1, 1, 0, 0, 8'hE4, 4'h0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2, 8'hE4, 4'h0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 2, 8'hE4, 4'h0, 2, 2, 1));
    tbl.push_back(mk(0, 0, 0, 0, 3, 8'hE4, 4'h0, 3, 3, 1));
    tbl.push_back(mk(0, 0, 1, 0, 3, 8'hE4, 4'h0, 0, 3, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 8'hE4, 4'h0, 0, 3, 0));
    tbl.push_back(mk(0, 0, 0, 0, 3, 8'hE4, 4'h0, 3, 3, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 8'hE4, 4'h0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h1B, 4'h0, 3, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 2, 8'h1B, 4'h0, 1, 2, 1));
    // N=3, D = 10_01_11; S=3 is out of range
    tbl.push_back(mk(1, 1, 1, 0, 0, 8'h27, 4'h0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 8'h27, 4'h0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 3, 8'h27, 4'h0, 0, 3, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 8'h27, 4'h0, 3, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 2, 8'h27, 4'h0, 2, 2, 1));

    foreach (tbl[i]) apply(tbl[i]);

    // N=4 scan from a MODE edge, with a 5-cycle freeze after channel 2's second cycle
    for (int k = 0; k < 20; k++) begin
      if (k == 10) begin
        for (int f = 0; f < 5; f++) apply(mk(0, 0, 1, 1, 0, 8'($urandom), 4'h0, 0, 2, 0));
      end
      d = 8'($urandom);
      c = (k / 4) % 4;
      apply(mk(0, 0, 0, 1, 0, d, 4'h0, sel(d, c), c, 1));
    end

    // Back to manual at once; scan position (channel 1, count 0) is kept
    d = 8'($urandom);
    apply(mk(0, 0, 0, 0, 1, d, 4'h0, sel(d, 1), 1, 1));
    // MODE rises while disabled: no restart when enable returns
    apply(mk(0, 0, 1, 1, 0, 8'hE4, 4'h0, 0, 1, 0));
    apply(mk(0, 0, 1, 1, 0, 8'hE4, 4'h0, 0, 1, 0));
    for (int k = 0; k < 5; k++) begin
      d = 8'($urandom);
      c = (k < 4) ? 1 : 2;
      apply(mk(0, 0, 0, 1, 0, d, 4'h0, sel(d, c), c, 1));
    end

    // N=3 scan, DWELL=2: wraps 2 -> 0
    for (int k = 0; k < 9; k++) begin
      d = 8'($urandom) & 8'h3F;
      c = (k / 2) % 3;
      apply(mk(1, 0, 0, 1, 0, d, 4'h0, sel(d, c), c, 1));
    end
    // Reset mid-dwell of channel 1, then scan restarts from channel 0
    apply(mk(1, 1, 0, 1, 0, 8'h3F, 4'h0, 0, 0, 0));
    for (int k = 0; k < 4; k++) begin
      d = 8'($urandom) & 8'h3F;
      c = (k / 2) % 3;
      apply(mk(1, 0, 0, 1, 0, d, 4'h0, sel(d, c), c, 1));
    end

`ifdef SCAN_CHMASK_EN
    // DWELL=1, channels 1 and 2 masked: 0,3,0,3; then everything masked
    apply(mk(2, 1, 1, 0, 0, 8'hE4, 4'h6, 0, 0, 0));
    for (int k = 0; k < 4; k++) begin
      c = (k % 2 == 0) ? 0 : 3;
      apply(mk(2, 0, 0, 1, 0, 8'hE4, 4'h6, sel(8'hE4, c), c, 1));
    end
    apply(mk(2, 0, 0, 1, 0, 8'hE4, 4'hF, 0, 0, 0));
    apply(mk(2, 0, 0, 1, 0, 8'hE4, 4'hF, 0, 0, 0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
